// File: rtl/multi_piso_tx_pkg.sv
// Shared types and helpers for the multi-channel parallel-in/serial-out transmitter.
package multi_piso_tx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2,
        DONE   = 2'd3
    } state_e;

    // Counter width for a terminal count of n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_piso_tx_hold_reg.sv
// One channel holding register: async clear, load enable, combinational bit select.
module multi_piso_tx_hold_reg
    import multi_piso_tx_pkg::*;
#(
    parameter int unsigned W = 4
) (
    input  logic                   clk,
    input  logic                   clr_n,
    input  logic                   ld_i,
    input  logic [W-1:0]           d_i,
    input  logic [cnt_w(W)-1:0]    idx_i,
    output logic                   bit_o
);

    logic [W-1:0] hold_q;
    logic [W-1:0] hold_d;

    always_comb begin
        hold_d = hold_q;
        if (ld_i) hold_d = d_i;
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) hold_q <= '0;
        else        hold_q <= hold_d;
    end

    assign bit_o = hold_q[idx_i];

endmodule

// File: rtl/multi_piso_tx.sv
// NCH x W frame transmitter: channel 0 first, optional LSB-first order and even parity.
module multi_piso_tx
    import multi_piso_tx_pkg::*;
#(
    parameter int unsigned NCH       = 4,
    parameter int unsigned W         = 4,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          PARITY_EN = 1'b0
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic [NCH-1:0]   ld,
    input  logic [NCH*W-1:0] data_in,
    input  logic             start,
    output logic             tx_data,
    output logic             tx_frame,
    output logic             busy,
    output logic             done
);

    localparam int unsigned BW        = cnt_w(W);
    localparam int unsigned CW        = cnt_w(NCH);
    localparam logic [BW-1:0] BIT_LAST = BW'(W - 1);
    localparam logic [CW-1:0] CH_LAST  = CW'(NCH - 1);
    localparam int unsigned FIRST_IDX = MSB_FIRST ? W - 1 : 0;

    state_e         state_q, state_d;
    logic [BW-1:0]  bit_cnt_q, bit_cnt_d, bit_nxt, pos, sel_idx;
    logic [CW-1:0]  ch_cnt_q, ch_cnt_d, ch_nxt, sel_ch;
    logic           par_q, par_d;
    logic           tx_data_d, tx_frame_d, busy_d, done_d;
    logic [NCH-1:0] ld_en, ch_bit;
    logic           sel_bit, first_bit, frame_last;

    // Counter advance: bit counter wraps at W-1 and carries into the channel counter.
    always_comb begin
        bit_nxt = bit_cnt_q + BW'(1);
        ch_nxt  = ch_cnt_q;
        if (bit_cnt_q == BIT_LAST) begin
            bit_nxt = '0;
            ch_nxt  = ch_cnt_q + CW'(1);
        end
    end

    assign frame_last = (bit_cnt_q == BIT_LAST) && (ch_cnt_q == CH_LAST);

    // The holding registers are looked up at the position about to be registered on tx_data.
    assign pos     = (state_q == IDLE) ? '0 : bit_nxt;
    assign sel_ch  = (state_q == IDLE) ? '0 : ch_nxt;
    assign sel_idx = MSB_FIRST ? (BIT_LAST - pos) : pos;
    assign ld_en   = (state_q == IDLE) ? ld : '0;

    for (genvar g = 0; g < NCH; g++) begin : g_hold
        multi_piso_tx_hold_reg #(.W(W)) u_hold (
            .clk   (clk),
            .clr_n (clr_n),
            .ld_i  (ld_en[g]),
            .d_i   (data_in[g*W +: W]),
            .idx_i (sel_idx),
            .bit_o (ch_bit[g])
        );
    end

    always_comb begin
        sel_bit = 1'b0;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (sel_ch == CW'(i)) sel_bit = ch_bit[i];
        end
    end

    // A same-edge load of channel 0 must already be reflected in the first bit.
    assign first_bit = ld[0] ? data_in[FIRST_IDX] : sel_bit;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (frame_last) state_d = PARITY_EN ? PARITY : DONE;
            PARITY:  state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bit_cnt_d  = bit_cnt_q;
        ch_cnt_d   = ch_cnt_q;
        par_d      = par_q;
        tx_data_d  = 1'b0;
        tx_frame_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    bit_cnt_d  = '0;
                    ch_cnt_d   = '0;
                    tx_frame_d = 1'b1;
                    busy_d     = 1'b1;
                    tx_data_d  = first_bit;
                    par_d      = first_bit;
                end
            end
            SHIFT: begin
                busy_d = 1'b1;
                if (!frame_last) begin
                    bit_cnt_d  = bit_nxt;
                    ch_cnt_d   = ch_nxt;
                    tx_frame_d = 1'b1;
                    tx_data_d  = sel_bit;
                    par_d      = par_q ^ sel_bit;
                end else if (PARITY_EN) begin
                    tx_frame_d = 1'b1;
                    tx_data_d  = par_q;
                end else begin
                    done_d = 1'b1;
                end
            end
            PARITY: begin
                busy_d = 1'b1;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bit_cnt_q <= '0;
            ch_cnt_q  <= '0;
            par_q     <= 1'b0;
            tx_data   <= 1'b0;
            tx_frame  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            ch_cnt_q  <= ch_cnt_d;
            par_q     <= par_d;
            tx_data   <= tx_data_d;
            tx_frame  <= tx_frame_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: doc/multi_piso_tx.md
Name: multi_piso_tx

Overview:
Parametrised parallel-in/serial-out frame transmitter with NCH channels of W bits each. Each channel has its own load strobe into a holding register. A synchronous start pulse serialises all channels onto one line, channel 0 first. Optional MSB/LSB-first ordering and a trailing even-parity bit. Successor to the fixed 4x4-bit transmitter in the serial link path; feeds the line driver / receiver bench.

Parameters:
NCH, 4, number of channels (>=2)
W, 4, bits per channel (>=2)
MSB_FIRST, 1, 1 = bit W-1 of each channel sent first; 0 = bit 0 first
PARITY_EN, 0, 1 = append one even-parity bit after the last data bit

Ports:
clk  in  1  system clock, all state on rising edge
clr_n  in  1  asynchronous active-low reset
ld  in  NCH  ld[i]=1 loads channel i holding register from data_in slice i
data_in  in  NCH*W  channel i occupies bits [i*W +: W]
start  in  1  request frame transmission (level sampled each cycle)
tx_data  out  1  serial data bit
tx_frame  out  1  high while tx_data carries a frame bit (data or parity)
busy  out  1  high from the cycle after accepted start through the DONE cycle
done  out  1  one-cycle pulse after the last frame bit

Behaviour:
- Reset (clr_n=0, async): state=IDLE; all holding registers, counters, tx_data, tx_frame, busy and done = 0. Reset mid-frame aborts immediately, with no done pulse.
- States: IDLE -> SHIFT -> (PARITY if PARITY_EN) -> DONE -> IDLE.
- IDLE: ld[i]=1 captures the slice at the clock edge. Multiple ld bits may be set in one cycle. ld is ignored in all other states.
- start=1 in IDLE accepts a frame: next cycle state=SHIFT, bit_cnt=0, ch_cnt=0, parity acc=0. If start and ld arrive together, the load completes first (same edge) and the new data is transmitted.
- start is ignored outside IDLE. Holding start high re-triggers only once the block has returned to IDLE.
- SHIFT: tx_frame=1. tx_data is a registered output equal to bit index (MSB_FIRST ? W-1-bit_cnt : bit_cnt) of channel ch_cnt.
  - bit_cnt wraps at W-1 and then increments ch_cnt.
  - After channel NCH-1, bit W-1 the state goes to PARITY or DONE.
  - Exactly NCH*W data cycles; first bit appears the cycle after the start-accept edge.
- PARITY: one cycle, tx_frame=1, tx_data = XOR of all NCH*W data bits sent (even parity).
- DONE: one cycle; done=1, busy=1, tx_frame=0, tx_data=0. Then IDLE.
- tx_data=0 whenever tx_frame=0.
- Holding registers are not destroyed by transmission; a new start without reload resends identical data.
- Counter widths: $clog2(W) and $clog2(NCH), minimum 1. Comparisons use terminal values W-1 and NCH-1, so non-power-of-two values work.
- Frame length L = NCH*W + PARITY_EN. done asserts L+1 cycles after the start-accept edge.

Decomposition:
- Shared package: state enum (IDLE, SHIFT, PARITY, DONE) and width-helper functions for counter sizes.
- One sub-module, tx_hold_reg: a W-bit register with async clear, load enable and a combinational bit-select output by index.
- multi_piso_tx instantiates NCH tx_hold_reg via generate, plus the FSM, the two counters and the output registers.

Test Plan:
1. NCH=4, W=4, MSB_FIRST=1, load 0xA, 0x3, 0xF, 0x0 then start -> tx_data 1010 0011 1111 0000 over 16 cycles with tx_frame=1; done pulses on cycle 17.
2. Same data, MSB_FIRST=0 -> 0101 1100 1111 0000; done on cycle 17.
3. PARITY_EN=1, load 0x1, 0x0, 0x0, 0x0 -> 16 data bits then parity bit 1; done on cycle 18. Load 0x3, 0x0, 0x0, 0x0 -> parity bit 0.
4. During SHIFT pulse ld=4'b1111 with new data and pulse start -> frame unchanged, no second frame. A later start resends the original data (retransmit without reload).
5. clr_n low at data bit 7 -> all outputs 0 asynchronously, no done. After release, holding registers read 0 and start sends all-zero frame.
6. NCH=3, W=5, data 0x1F, 0x00, 0x15, MSB_FIRST=1 -> 11111 00000 10101; done on cycle 16.
